custom_protocol: RTL and testbench
==================================

// Module: custom_protocol
// PURPOSE
// - Half-duplex 4-bit nibble link framer sitting between a master-side and a slave-side bus.
// - direction_pin selects the transmitting side; the active bus is monitored for a start condition
//   (1111 then 0000), after which 4 data nibbles are captured into a frame buffer and flagged valid.
// PARAMETERS
// - DATA_W         4   width of each data bus / nibble
// - FRAME_NIBBLES  4   data nibbles per frame (counter width = clog2, min 1)
// PORTS
// - clk                            in   1    single clock, all logic on posedge
// - rst                            in   1    synchronous, active-high reset
// - direction_pin                  in   1    1 = master->slave (watch master_data_in), 0 = slave->master (watch slave_data_in)
// - strobe_pin                     in   1    1 = bus sample enabled this cycle; 0 = FSM/counters hold
// - master_data_in                 in   4    master-side bus
// - slave_data_in                  in   4    slave-side bus
// - master_data_buffer_out         out  16   last master->slave frame; nibble n at [4n+3:4n]
// - slave_data_buffer_out          out  16   last slave->master frame; same layout
// - start_condition_master_t_slave out  1    1-cycle pulse: start detected, direction 1
// - start_condition_slave_t_master out  1    1-cycle pulse: start detected, direction 0
// - valid                          out  1    1-cycle pulse: frame complete, buffer updated
// - busy                           out  1    1 while in START_ONES or RECV
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is synchronous, active-high.
// - Active bus: bus = direction_pin ? master_data_in : slave_data_in (combinational mux).
// - States: IDLE, START_ONES, RECV. Transitions happen only on posedges with strobe_pin=1.
// - IDLE: bus==1111 -> START_ONES; otherwise stay.
// - START_ONES: 1111 -> stay; 0000 -> RECV, cnt<=0, registered start pulse for the active direction
//   high the next cycle; any other value -> IDLE.
// - RECV: each strobed edge writes bus into shadow nibble[cnt], cnt++. 1111/0000 are ordinary data here.
//   On edge with cnt==FRAME_NIBBLES-1: copy complete frame (incl. this nibble) to the buffer of the
//   direction active at frame start; valid=1 next cycle; -> IDLE.
// - Latency: 1111 at edge k, 0000 at k+1 -> start pulse during cycle after k+1; data at k+2..k+5;
//   buffer updated and valid high from edge k+5 for one cycle.
// - Back-to-back: a 1111 on the edge right after the last data nibble is accepted (IDLE -> START_ONES).
// - direction_pin change while busy: abort to IDLE, discard partial frame, no valid, buffers unchanged.
// - strobe_pin=0: state, cnt, shadow hold; pulses still deassert after their one cycle.
// - Buffers change only on frame completion; the other direction's buffer is never touched.
// - Reset (any time, incl. mid-frame): state IDLE, cnt 0, both buffers 0, valid/start/busy 0.
// CONFIGURATION
// - FRAME_COUNT_EN defined: adds output frame_count [15:0]; reset 0; +1 on each valid pulse;
//   wraps FFFF->0000.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - rst=1 one cycle, dir=1, strobe=1 -> all outputs 0, busy 0.
// - dir=1: master bus 1111,0000,A,3,F,0 -> start_condition_master_t_slave pulse; valid pulse;
//   master_data_buffer_out=16'h0F3A; slave_data_buffer_out unchanged.
// - dir=0: slave bus 1111,0000,1,2,3,4 -> start_condition_slave_t_master pulse;
//   slave_data_buffer_out=16'h4321.
// - 1111,0101 -> back to IDLE, no start; then 1111,1111,0000,5,5,5,5 -> valid, buffer 16'h5555.
// - strobe_pin=0 for 2 cycles between data nibbles 2 and 3 -> same frame captured, valid delayed 2 cycles.
// - direction flips after 2nd data nibble, or rst mid-frame -> no valid; buffer unchanged (rst: cleared to 0).

Source files
------------

// File: rtl/custom_protocol_if.sv
// custom_protocol_if: nibble-link bus bundle; the master modport drives the link, the slave modport is the framer.
interface custom_protocol_if #(
    parameter int DATA_W        = 4,
    parameter int FRAME_NIBBLES = 4
);
    localparam int BUF_W = DATA_W * FRAME_NIBBLES;
    logic              direction_pin;
    logic              strobe_pin;
    logic [DATA_W-1:0] master_data_in;
    logic [DATA_W-1:0] slave_data_in;
    logic [BUF_W-1:0]  master_data_buffer_out;
    logic [BUF_W-1:0]  slave_data_buffer_out;
    logic              start_condition_master_t_slave;
    logic              start_condition_slave_t_master;
    logic              valid;
    logic              busy;
    modport master (
        output direction_pin, strobe_pin, master_data_in, slave_data_in,
        input  master_data_buffer_out, slave_data_buffer_out,
               start_condition_master_t_slave, start_condition_slave_t_master, valid, busy
    );
    modport slave (
        input  direction_pin, strobe_pin, master_data_in, slave_data_in,
        output master_data_buffer_out, slave_data_buffer_out,
               start_condition_master_t_slave, start_condition_slave_t_master, valid, busy
    );
endinterface

// File: rtl/custom_protocol.sv
// custom_protocol: half-duplex nibble framer; start = 1111 then 0000, then FRAME_NIBBLES data nibbles.
// Define FRAME_COUNT_EN to add a 16-bit wrapping frame_count output.
module custom_protocol #(
    parameter int DATA_W        = 4,
    parameter int FRAME_NIBBLES = 4
) (
    input logic clk,
    input logic rst,
`ifdef FRAME_COUNT_EN
    custom_protocol_if.slave io,
    output logic [15:0] frame_count
`else
    custom_protocol_if.slave io
`endif
);
    localparam int BUF_W = DATA_W * FRAME_NIBBLES;
    localparam int CNT_W = FRAME_NIBBLES > 1 ? $clog2(FRAME_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_NIBBLES - 1);
    typedef enum logic [1:0] {IDLE, START_ONES, RECV} state_t;
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [BUF_W-1:0]   r_shadow, r_mbuf, r_sbuf, w_frame;
    logic               r_dir, r_start_m, r_start_s, r_valid;
    logic               w_start, w_recv, w_done, w_abort;
    logic [DATA_W-1:0]  w_bus;
    assign w_bus = io.direction_pin ? io.master_data_in : io.slave_data_in;
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_recv  = 1'b0;
        w_done  = 1'b0;
        w_frame = r_shadow;
        w_frame[r_cnt*DATA_W +: DATA_W] = w_bus;
        // a direction change mid-frame abandons the frame rather than mixing buses
        w_abort = io.strobe_pin && r_state != IDLE && io.direction_pin != r_dir;
        if (w_abort)
            w_next = IDLE;
        else if (io.strobe_pin && r_state == IDLE)
            w_next = &w_bus ? START_ONES : IDLE;
        else if (io.strobe_pin && r_state == START_ONES) begin
            w_start = ~|w_bus;
            w_next  = &w_bus ? START_ONES : w_start ? RECV : IDLE;
        end else if (io.strobe_pin && r_state == RECV) begin
            w_recv = 1'b1;
            w_done = r_cnt == LAST;
            w_next = w_done ? IDLE : RECV;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_mbuf    <= '0;
            r_sbuf    <= '0;
            r_dir     <= 1'b0;
            r_start_m <= 1'b0;
            r_start_s <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_m <= w_start && r_dir;
            r_start_s <= w_start && !r_dir;
            r_valid   <= w_done;
            if (io.strobe_pin && r_state == IDLE)
                r_dir <= io.direction_pin;
            if (w_start)
                r_cnt <= '0;
            else if (w_recv) begin
                r_shadow <= w_frame;
                r_cnt    <= w_done ? '0 : r_cnt + 1'b1;
            end
            if (w_done && r_dir)
                r_mbuf <= w_frame;
            if (w_done && !r_dir)
                r_sbuf <= w_frame;
        end
    end
`ifdef FRAME_COUNT_EN
    logic [15:0] r_fc;
    always_ff @(posedge clk) begin
        if (rst)
            r_fc <= '0;
        else if (w_done)
            r_fc <= r_fc + 16'd1;
    end
    assign frame_count = r_fc;
`endif
    assign io.master_data_buffer_out         = r_mbuf;
    assign io.slave_data_buffer_out          = r_sbuf;
    assign io.start_condition_master_t_slave = r_start_m;
    assign io.start_condition_slave_t_master = r_start_s;
    assign io.valid                          = r_valid;
    assign io.busy                           = r_state != IDLE;
endmodule

// File: tb/tb_custom_protocol.sv
// tb_custom_protocol: scoreboard bench; expected frames are queued at the last nibble and popped on valid.
module tb_custom_protocol;
    typedef struct {logic dir; logic [15:0] data;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int n_sm = 0;
    int n_ss = 0;
    int n_v = 0;
    logic [15:0] mod_m = '0;
    logic [15:0] mod_s = '0;
    exp_t q[$];
    custom_protocol_if cp ();
    custom_protocol dut (.clk(clk), .rst(rst), .io(cp));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    always @(negedge clk) begin
        exp_t e;
        if (cp.start_condition_master_t_slave) n_sm++;
        if (cp.start_condition_slave_t_master) n_ss++;
        if (cp.valid) begin
            n_v++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got valid=1 with no frame expected");
            end else begin
                e = q.pop_front();
                if (e.dir) mod_m = e.data; else mod_s = e.data;
                total++;
                if (cp.master_data_buffer_out !== mod_m) begin
                    bad++;
                    $display("FAIL master_buf_on_valid: got %h expected %h", cp.master_data_buffer_out, mod_m);
                end
                total++;
                if (cp.slave_data_buffer_out !== mod_s) begin
                    bad++;
                    $display("FAIL slave_buf_on_valid: got %h expected %h", cp.slave_data_buffer_out, mod_s);
                end
            end
        end
    end
    task automatic step(input logic d, input logic s, input logic [3:0] nib);
        cp.direction_pin = d;
        cp.strobe_pin = s;
        cp.master_data_in = d ? nib : ~nib;
        cp.slave_data_in = d ? ~nib : nib;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic d, input logic [15:0] data);
        exp_t e;
        step(d, 1'b1, 4'hF);
        step(d, 1'b1, 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                e.dir = d;
                e.data = data;
                q.push_back(e);
            end
            step(d, 1'b1, data[4*i +: 4]);
        end
    endtask
    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask
    task automatic check_bufs(input string name);
        total++;
        if (cp.master_data_buffer_out !== mod_m || cp.slave_data_buffer_out !== mod_s) begin
            bad++;
            $display("FAIL %s: got m=%h s=%h expected m=%h s=%h", name,
                     cp.master_data_buffer_out, cp.slave_data_buffer_out, mod_m, mod_s);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        cp.direction_pin = 1'b1;
        cp.strobe_pin = 1'b1;
        cp.master_data_in = 4'h0;
        cp.slave_data_in = 4'h0;
        @(posedge clk);
        #1;
        total++;
        if ({cp.master_data_buffer_out, cp.slave_data_buffer_out, cp.start_condition_master_t_slave,
             cp.start_condition_slave_t_master, cp.valid, cp.busy} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: got m=%h s=%h sm=%b ss=%b v=%b busy=%b expected all 0",
                     cp.master_data_buffer_out, cp.slave_data_buffer_out, cp.start_condition_master_t_slave,
                     cp.start_condition_slave_t_master, cp.valid, cp.busy);
        end
        rst = 1'b0;
    endtask
    task automatic test_master_frame();
        int sm0 = n_sm, v0 = n_v;
        send(1'b1, 16'h0F3A);
        step(1'b1, 1'b1, 4'h0);
        check_int("master_start_pulses", n_sm - sm0, 1);
        check_int("master_valid_pulses", n_v - v0, 1);
        check_bufs("master_frame_bufs");
    endtask
    task automatic test_slave_frame();
        int ss0 = n_ss, sm0 = n_sm, v0 = n_v;
        send(1'b0, 16'h4321);
        step(1'b0, 1'b1, 4'h0);
        check_int("slave_start_pulses", n_ss - ss0, 1);
        check_int("slave_no_master_start", n_sm - sm0, 0);
        check_int("slave_valid_pulses", n_v - v0, 1);
        check_bufs("slave_frame_bufs");
    endtask
    task automatic test_bad_start();
        int sm0 = n_sm, v0 = n_v;
        step(1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'h0);
        check_int("bad_start_no_pulse", n_sm - sm0, 0);
        check_int("bad_start_busy", int'(cp.busy), 0);
        step(1'b1, 1'b1, 4'hF);
        send(1'b1, 16'h5555);
        step(1'b1, 1'b1, 4'h0);
        check_int("repeat_ones_start", n_sm - sm0, 1);
        check_int("repeat_ones_valid", n_v - v0, 1);
        check_bufs("repeat_ones_bufs");
    endtask
    task automatic test_strobe();
        int v0 = n_v;
        exp_t e;
        step(1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b1, 4'h8);
        step(1'b1, 1'b0, 4'hF);
        step(1'b1, 1'b0, 4'h0);
        check_int("strobe_hold_busy", int'(cp.busy), 1);
        step(1'b1, 1'b1, 4'h9);
        e.dir = 1'b1;
        e.data = 16'hA987;
        q.push_back(e);
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h0);
        check_int("strobe_valid_pulses", n_v - v0, 1);
        check_bufs("strobe_bufs");
    endtask
    task automatic test_back_to_back();
        int v0 = n_v, sm0 = n_sm;
        send(1'b1, 16'h1234);
        send(1'b1, 16'h8765);
        step(1'b1, 1'b1, 4'h0);
        check_int("b2b_start_pulses", n_sm - sm0, 2);
        check_int("b2b_valid_pulses", n_v - v0, 2);
        check_bufs("b2b_bufs");
    endtask
    task automatic test_abort();
        int v0 = n_v;
        step(1'b1, 1'b1, 4'hF);
        check_int("abort_busy_start", int'(cp.busy), 1);
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'h2);
        step(1'b0, 1'b1, 4'h0);
        check_int("abort_busy_cleared", int'(cp.busy), 0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b1, 4'h4);
        check_int("abort_no_valid", n_v - v0, 0);
        check_bufs("abort_bufs");
    endtask
    task automatic test_reset_mid();
        int v0 = n_v;
        step(1'b0, 1'b1, 4'hF);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h1);
        rst = 1'b1;
        step(1'b0, 1'b1, 4'h2);
        rst = 1'b0;
        mod_m = '0;
        mod_s = '0;
        check_bufs("mid_reset_bufs");
        check_int("mid_reset_busy", int'(cp.busy), 0);
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'h0);
        check_int("mid_reset_no_valid", n_v - v0, 0);
        check_bufs("mid_reset_bufs_after");
    endtask
    initial begin
        test_reset();
        test_master_frame();
        test_slave_frame();
        test_bad_start();
        test_strobe();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        check_int("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
